pipe_buffer: RTL and testbench
==============================

PIPE_BUFFER -- requirements
Module: pipe_buffer

Interface
REQ-001 Parameter DW, default 16, width of one data lane in bits.
REQ-002 Parameter LANES, default 4, number of data lanes per entry (address, r0 data, Din, instruction).
REQ-003 Parameter CW, default 4, number of control bits per entry (wEnable, mux3 select, regWrite, r0write).
REQ-004 Parameter SCW, default 8, width of the stall counter.
REQ-005 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-006 rst_n  input  1  reset; synchronous and active-low.
REQ-007 in_valid  input  1  upstream stage presents an entry.
REQ-008 in_ready  output  1  block can accept an entry this cycle.
REQ-009 in_data  input  LANES*DW  lane k at bits [k*DW +: DW].
REQ-010 in_ctrl  input  CW  control bits accompanying in_data.
REQ-011 flush  input  1  kill all held entries (branch/exception squash).
REQ-012 out_valid  output  1  downstream stage sees a valid entry.
REQ-013 out_ready  input  1  downstream stage consumes the entry this cycle.
REQ-014 out_data  output  LANES*DW  data of the head entry.
REQ-015 out_ctrl  output  CW  control of the head entry; all zero when out_valid=0.
REQ-016 stall_cnt  output  SCW  saturating count of back-pressure cycles.

Function
REQ-017 Storage SHALL be two entries: main (drives outputs) and skid; each holds data, ctrl and a valid bit.
REQ-018 Input transfer occurs when in_valid=1 and in_ready=1; output transfer when out_valid=1 and out_ready=1.
REQ-019 in_ready SHALL be a registered signal equal to NOT skid.valid; no combinational path from out_ready to in_ready.
REQ-020 out_valid SHALL equal main.valid; out_data SHALL equal main.data.
REQ-021 Latency: an entry accepted into an empty block SHALL appear on out_valid on the next cycle.
REQ-022 Throughput: with out_ready held at 1, one entry per cycle SHALL pass with no bubbles.
REQ-023 Main empty or popping, skid empty, input transfer: main loads input.
REQ-024 Main full and not popping, input transfer: skid loads input.
REQ-025 Main pops, skid full: main loads skid, skid becomes empty; in_ready rises on the following cycle.
REQ-026 Neither pop nor push: all entries hold; out_data remains stable while out_valid=1 and out_ready=0.
REQ-027 Entry order SHALL be preserved; no entry duplicated or lost except by flush.
REQ-028 When out_valid=0, out_ctrl SHALL be forced to zero (pipeline bubble); out_data holds its last value.
REQ-029 flush=1 SHALL clear both valid bits at the edge; an input presented in the same cycle SHALL be discarded; in_ready is 1 on the next cycle.
REQ-030 flush overrides every simultaneous push and pop.
REQ-031 stall_cnt SHALL increment when out_valid=1 and out_ready=0, saturate at 2^SCW-1, and be unaffected by flush.

Reset
REQ-032 rst_n=0 at a rising edge SHALL clear both valid bits, main.data, main.ctrl and stall_cnt to zero and set in_ready to 1.
REQ-033 Reset mid-transfer SHALL discard all held entries; the first accept after reset follows REQ-021.
REQ-034 Skid data/ctrl need no reset.

Structure
REQ-035 Package pipe_pkg SHALL hold the default DW, LANES, CW and SCW values and the control-bit index constants (WEN, MUX3SEL, REGWR, R0WR).
REQ-036 One sub-module, pipe_entry (valid+data+ctrl register with load/clear enables), SHALL be instantiated twice.

Verification
REQ-037 Reset, then in_valid=1 with lane0=16'h1234, ctrl=4'b0101, out_ready=1 -> out_valid=1, out_data lane0=16'h1234, out_ctrl=4'b0101 exactly one cycle later.
REQ-038 Stream of 8 entries 0..7 with out_ready=1 -> 8 consecutive output cycles, order 0..7, in_ready always 1.
REQ-039 out_ready=0, push A then B -> in_ready=0 after B, out holds A, stall_cnt counts; out_ready=1 -> A then B; in_ready returns to 1.
REQ-040 Both entries full, flush=1 together with in_valid=1 carrying C -> next cycle out_valid=0, out_ctrl=0, C never emitted.
REQ-041 out_ready=0 with valid head held for 300 cycles, SCW=8 -> stall_cnt saturates at 255.
REQ-042 rst_n=0 asserted while skid full -> next cycle out_valid=0, in_ready=1, stall_cnt=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared defaults and control-bit indices for the pipeline buffer
package pipe_pkg;

    localparam int PIPE_DW    = 16;
    localparam int PIPE_LANES = 4;
    localparam int PIPE_CW    = 4;
    localparam int PIPE_SCW   = 8;

    // Positions of the control bits carried alongside each entry
    localparam int WEN     = 0;
    localparam int MUX3SEL = 1;
    localparam int REGWR   = 2;
    localparam int R0WR    = 3;

endpackage

// File: rtl/pipe_entry.sv
// rtl/pipe_entry.sv - one buffer slot: valid flag plus data/ctrl payload with load and clear
module pipe_entry #(
    parameter int DATA_W        = 64,
    parameter int CTRL_W        = 4,
    parameter bit RESET_PAYLOAD = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;

    // Clear wins over load so a squash can never be overridden by a fill
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            if (RESET_PAYLOAD) begin
                r_data <= '0;
                r_ctrl <= '0;
            end
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_ctrl  <= i_ctrl;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/pipe_buffer.sv
// rtl/pipe_buffer.sv - two-entry skid buffer between pipeline stages with flush and stall counter
module pipe_buffer
    import pipe_pkg::*;
#(
    parameter int DW    = PIPE_DW,
    parameter int LANES = PIPE_LANES,
    parameter int CW    = PIPE_CW,
    parameter int SCW   = PIPE_SCW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LANES*DW-1:0] in_data,
    input  logic [CW-1:0]       in_ctrl,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LANES*DW-1:0] out_data,
    output logic [CW-1:0]       out_ctrl,
    output logic [SCW-1:0]      stall_cnt
);

    localparam int DATA_W = LANES * DW;

    logic              r_in_ready;
    logic [SCW-1:0]    r_stall_cnt;

    logic              w_main_valid, w_skid_valid;
    logic [DATA_W-1:0] w_main_data, w_skid_data, w_main_src_data;
    logic [CW-1:0]     w_main_ctrl, w_skid_ctrl, w_main_src_ctrl;
    logic              w_pop, w_push, w_main_free;
    logic              w_main_load, w_main_clear;
    logic              w_skid_load, w_skid_clear, w_skid_valid_nxt;

    assign w_pop       = w_main_valid & out_ready;
    assign w_push      = in_valid & r_in_ready;
    assign w_main_free = ~w_main_valid | w_pop;

    // A held skid entry always refills main before any new input can
    assign w_main_load  = ~flush & w_main_free & (w_skid_valid | w_push);
    assign w_main_clear = flush | (w_pop & ~w_skid_valid & ~w_push);
    assign w_skid_load  = ~flush & ~w_main_free & w_push;
    assign w_skid_clear = flush | (w_main_free & w_skid_valid);

    assign w_main_src_data = w_skid_valid ? w_skid_data : in_data;
    assign w_main_src_ctrl = w_skid_valid ? w_skid_ctrl : in_ctrl;

    assign w_skid_valid_nxt = ~flush & (w_skid_load | (w_skid_valid & ~w_skid_clear));

    pipe_entry #(
        .DATA_W        (DATA_W),
        .CTRL_W        (CW),
        .RESET_PAYLOAD (1'b1)
    ) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_data  (w_main_src_data),
        .i_ctrl  (w_main_src_ctrl),
        .o_valid (w_main_valid),
        .o_data  (w_main_data),
        .o_ctrl  (w_main_ctrl)
    );

    pipe_entry #(
        .DATA_W        (DATA_W),
        .CTRL_W        (CW),
        .RESET_PAYLOAD (1'b0)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (in_data),
        .i_ctrl  (in_ctrl),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data),
        .o_ctrl  (w_skid_ctrl)
    );

    // in_ready tracks the registered skid state, so out_ready never reaches it combinationally
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_in_ready <= 1'b1;
        end else begin
            r_in_ready <= ~w_skid_valid_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_main_valid && !out_ready && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + SCW'(1);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = w_main_valid;
    assign out_data  = w_main_data;
    assign out_ctrl  = w_main_valid ? w_main_ctrl : '0;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_buffer.sv
// tb/tb_pipe_buffer.sv - directed self-checking bench for pipe_buffer
module tb_pipe_buffer;
    import pipe_pkg::*;

    localparam int DW    = 16;
    localparam int LANES = 4;
    localparam int CW    = 4;
    localparam int SCW   = 8;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [LANES*DW-1:0] in_data;
    logic [CW-1:0]       in_ctrl;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [LANES*DW-1:0] out_data;
    logic [CW-1:0]       out_ctrl;
    logic [SCW-1:0]      stall_cnt;

    int n_checks;
    int n_fail;

    pipe_buffer #(.DW(DW), .LANES(LANES), .CW(CW), .SCW(SCW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [LANES*DW-1:0] mk(input logic [DW-1:0] v);
        return {v + 16'h0300, v + 16'h0200, v + 16'h0100, v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
        flush = 1'b0; out_ready = 1'b0;
        tick(); tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_checks++; if (stall_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
        n_checks++; if (out_ctrl !== 4'b0) begin n_fail++; $display("FAIL reset_out_ctrl got %b want 0", out_ctrl); end
        n_checks++; if (out_data !== 64'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_latency();
        logic [CW-1:0] c;
        c = '0; c[WEN] = 1'b1; c[REGWR] = 1'b1;
        in_valid = 1'b1; in_data = mk(16'h1234); in_ctrl = c; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_out_valid got %b want 1", out_valid); end
        n_checks++; if (out_data[15:0] !== 16'h1234) begin n_fail++; $display("FAIL lat_lane0 got %h want 1234", out_data[15:0]); end
        n_checks++; if (out_data !== 64'h1534_1434_1334_1234) begin n_fail++; $display("FAIL lat_data got %h want 1534143413341234", out_data); end
        n_checks++; if (out_ctrl !== 4'b0101) begin n_fail++; $display("FAIL lat_out_ctrl got %b want 0101", out_ctrl); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_drain got %b want 0", out_valid); end
        n_checks++; if (out_ctrl !== 4'b0) begin n_fail++; $display("FAIL bubble_ctrl got %b want 0", out_ctrl); end
        n_checks++; if (out_data[15:0] !== 16'h1234) begin n_fail++; $display("FAIL bubble_data_hold got %h want 1234", out_data[15:0]); end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = mk(16'(i)); in_ctrl = 4'(i);
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d] got %b want 1", i, in_ready); end
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== mk(16'(i)) || out_ctrl !== 4'(i)) begin
                n_fail++; $display("FAIL stream_out[%0d] got v=%b d=%h c=%h want v=1 d=%h c=%h", i, out_valid, out_data, out_ctrl, mk(16'(i)), 4'(i));
            end
        end
        in_valid = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_end got %b want 0", out_valid); end
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = mk(16'h00A0); in_ctrl = 4'hA;
        tick();
        n_checks++; if (out_data !== mk(16'h00A0) || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_A got d=%h rdy=%b want d=%h rdy=1", out_data, in_ready, mk(16'h00A0)); end
        in_data = mk(16'h00B0); in_ctrl = 4'hB;
        tick();
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full got %b want 0", in_ready); end
        n_checks++; if (out_data !== mk(16'h00A0) || out_ctrl !== 4'hA) begin n_fail++; $display("FAIL bp_hold_A got %h/%h want %h/a", out_data, out_ctrl, mk(16'h00A0)); end
        n_checks++; if (stall_cnt !== 8'd1) begin n_fail++; $display("FAIL bp_stall1 got %0d want 1", stall_cnt); end
        tick();
        n_checks++; if (stall_cnt !== 8'd2 || out_data !== mk(16'h00A0)) begin n_fail++; $display("FAIL bp_stall2 got %0d d=%h want 2 d=%h", stall_cnt, out_data, mk(16'h00A0)); end
        out_ready = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_data !== mk(16'h00B0) || out_ctrl !== 4'hB) begin n_fail++; $display("FAIL bp_B got v=%b d=%h c=%h want v=1 d=%h c=b", out_valid, out_data, out_ctrl, mk(16'h00B0)); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back got %b want 1", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b0 || stall_cnt !== 8'd2) begin n_fail++; $display("FAIL bp_drain got v=%b s=%0d want v=0 s=2", out_valid, stall_cnt); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = mk(16'h00D0); in_ctrl = 4'hD;
        tick();
        in_data = mk(16'h00E0); in_ctrl = 4'hE;
        tick();
        n_checks++; if (in_ready !== 1'b0 || stall_cnt !== 8'd3) begin n_fail++; $display("FAIL fl_full got rdy=%b s=%0d want rdy=0 s=3", in_ready, stall_cnt); end
        flush = 1'b1; out_ready = 1'b1; in_data = mk(16'h00C0); in_ctrl = 4'hC;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || out_ctrl !== 4'b0) begin n_fail++; $display("FAIL fl_cleared got v=%b c=%b want v=0 c=0", out_valid, out_ctrl); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fl_ready got %b want 1", in_ready); end
        n_checks++; if (stall_cnt !== 8'd3) begin n_fail++; $display("FAIL fl_stall_kept got %0d want 3", stall_cnt); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_no_C got %b want 0", out_valid); end
        flush = 1'b1; in_valid = 1'b1; in_data = mk(16'h00C1); in_ctrl = 4'hC;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_discard_push got %b want 0", out_valid); end
    endtask

    task automatic test_saturate();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = mk(16'h00F0); in_ctrl = 4'hF;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 300; i++) tick();
        n_checks++; if (stall_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_stall got %0d want 255", stall_cnt); end
        n_checks++; if (out_valid !== 1'b1 || out_data !== mk(16'h00F0)) begin n_fail++; $display("FAIL sat_hold got v=%b d=%h want v=1 d=%h", out_valid, out_data, mk(16'h00F0)); end
    endtask

    task automatic test_reset_midflight();
        in_valid = 1'b1; in_data = mk(16'h0011); in_ctrl = 4'h1;
        tick();
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rm_skid_full got %b want 0", in_ready); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || stall_cnt !== 8'd0) begin n_fail++; $display("FAIL rm_reset got v=%b rdy=%b s=%0d want v=0 rdy=1 s=0", out_valid, in_ready, stall_cnt); end
        out_ready = 1'b1; in_valid = 1'b1; in_data = mk(16'h0022); in_ctrl = 4'h2;
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_data !== mk(16'h0022) || out_ctrl !== 4'h2) begin n_fail++; $display("FAIL rm_first got v=%b d=%h c=%h want v=1 d=%h c=2", out_valid, out_data, out_ctrl, mk(16'h0022)); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_no_stale got %b want 0", out_valid); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_latency();
        test_stream();
        test_back_pressure();
        test_flush();
        test_saturate();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
